// File: rtl/bird_pkg.sv
// rtl/bird_pkg.sv - shared state encoding and default physics constants for bird_physics
//
// Purpose : state enum used on the bird_physics state port, plus the default
//           parameter values for the physics block and its frame tick generator.
// Ports   : none (package)
package bird_pkg;

  // Encoding is visible on the state output port, so values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DEAD = 2'd2
  } bird_state_e;

  localparam int DEF_Y_W      = 9;
  localparam int DEF_V_W      = 6;
  localparam int DEF_TICK_DIV = 1666667;  // 60 Hz frames from a 100 MHz clock
  localparam int DEF_GRAVITY  = 1;
  localparam int DEF_FLAP_VEL = 8;
  localparam int DEF_V_MAX    = 12;
  localparam int DEF_Y_TOP    = 0;
  localparam int DEF_Y_FLOOR  = 440;
  localparam int DEF_Y_START  = 240;

  // Width needed to count 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bird_tick_gen.sv
// rtl/bird_tick_gen.sv - free-running frame counter producing a one-cycle tick
//
// Purpose : counts 0..TICK_DIV-1 and wraps; tick is high for the cycle in which
//           the count equals TICK_DIV-1.
// Ports   : clk   - system clock, rising edge
//           rst_n - asynchronous active-low reset, clears the count
//           tick  - one-cycle frame pulse
module bird_tick_gen
  import bird_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = cnt_width(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // With TICK_DIV >= 2 the reset count of 0 guarantees tick is low in reset.
  if (TICK_DIV < 2) begin : g_bad_div
    $error("bird_tick_gen: TICK_DIV must be at least 2");
  end

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/bird_physics.sv
// rtl/bird_physics.sv - flappy-bird vertical physics: flap sync, frame update, game FSM
//
// Purpose : synchronises the raw flap button, latches flap edges between frames,
//           and on each frame tick integrates gravity / flap impulse into the
//           bird's velocity and row, clamping at floor (death) and ceiling.
// Config  : define BIRD_CEIL_KILL_EN to make a ceiling hit fatal; otherwise the
//           bird is clamped at Y_TOP and keeps playing.
// Ports   : clk   - system clock, rising edge
//           rst_n - asynchronous active-low reset
//           flap  - raw asynchronous button level
//           start - synchronous level, begins a game (IDLE) or restarts (DEAD)
//           y     - registered bird row (unsigned)
//           vel   - registered velocity, signed, positive is downward
//           state - IDLE=0, PLAY=1, DEAD=2
//           dead  - high while in DEAD
//           tick  - one-cycle frame pulse
module bird_physics
  import bird_pkg::*;
#(
  parameter int Y_W      = DEF_Y_W,
  parameter int V_W      = DEF_V_W,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int GRAVITY  = DEF_GRAVITY,
  parameter int FLAP_VEL = DEF_FLAP_VEL,
  parameter int V_MAX    = DEF_V_MAX,
  parameter int Y_TOP    = DEF_Y_TOP,
  parameter int Y_FLOOR  = DEF_Y_FLOOR,
  parameter int Y_START  = DEF_Y_START
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flap,
  input  logic                  start,
  output logic [Y_W-1:0]        y,
  output logic signed [V_W-1:0] vel,
  output logic [1:0]            state,
  output logic                  dead,
  output logic                  tick
);

  // Physics is evaluated two bits wider than the row so that both an
  // overshoot below zero and past the floor are representable as signed.
  localparam int PW = Y_W + 2;

  localparam logic signed [PW-1:0] G_S     = PW'(GRAVITY);
  localparam logic signed [PW-1:0] FLAP_S  = PW'(FLAP_VEL);
  localparam logic signed [PW-1:0] VMAX_S  = PW'(V_MAX);
  localparam logic signed [PW-1:0] TOP_S   = PW'(Y_TOP);
  localparam logic signed [PW-1:0] FLOOR_S = PW'(Y_FLOOR);

  localparam logic [Y_W-1:0] Y_START_V = Y_W'(Y_START);
  localparam logic [Y_W-1:0] Y_TOP_V   = Y_W'(Y_TOP);
  localparam logic [Y_W-1:0] Y_FLOOR_V = Y_W'(Y_FLOOR);

  // Elaboration-time parameter sanity. Ordering of the rows is what makes a
  // simultaneous floor and ceiling hit impossible.
  if (!((Y_TOP < Y_START) && (Y_START < Y_FLOOR))) begin : g_bad_rows
    $error("bird_physics: require Y_TOP < Y_START < Y_FLOOR");
  end
  if (Y_FLOOR >= (1 << Y_W)) begin : g_bad_floor
    $error("bird_physics: Y_FLOOR does not fit in Y_W bits");
  end
  if ((V_MAX >= (1 << (V_W - 1))) || (FLAP_VEL > (1 << (V_W - 1)))) begin : g_bad_vel
    $error("bird_physics: V_MAX / FLAP_VEL do not fit in signed V_W bits");
  end
  if (PW <= V_W) begin : g_bad_widths
    $error("bird_physics: Y_W + 2 must exceed V_W");
  end

  // ---------------------------------------------------------------------
  // Flap synchroniser and rising-edge detect
  // ---------------------------------------------------------------------
  logic flap_s1_q;
  logic flap_s2_q;
  logic flap_s3_q;
  logic flap_edge_q;

  // Two metastability flops, a history flop, and a registered edge pulse:
  // the pulse lands in the third cycle after the button rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flap_s1_q   <= 1'b0;
      flap_s2_q   <= 1'b0;
      flap_s3_q   <= 1'b0;
      flap_edge_q <= 1'b0;
    end else begin
      flap_s1_q   <= flap;
      flap_s2_q   <= flap_s1_q;
      flap_s3_q   <= flap_s2_q;
      flap_edge_q <= flap_s2_q & ~flap_s3_q;
    end
  end

  // ---------------------------------------------------------------------
  // Frame tick
  // ---------------------------------------------------------------------
  logic tick_w;

  bird_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick_w)
  );

  assign tick = tick_w;

  // ---------------------------------------------------------------------
  // Physics datapath
  // ---------------------------------------------------------------------
  bird_state_e           state_q, state_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic signed [V_W-1:0] vel_q, vel_d;
  logic                  pend_q, pend_d;

  logic                  flap_now;
  logic signed [PW-1:0]  vel_ext;
  logic signed [PW-1:0]  vel_inc;
  logic signed [PW-1:0]  vel_n;
  logic signed [PW-1:0]  y_n;

  // An edge arriving in the tick cycle itself is folded in here, so it is
  // honoured by that tick rather than waiting for the next frame.
  assign flap_now = pend_q | flap_edge_q;

  assign vel_ext = {{(PW - V_W){vel_q[V_W-1]}}, vel_q};
  assign vel_inc = vel_ext + G_S;
  assign vel_n   = flap_now          ? -FLAP_S :
                   (vel_inc > VMAX_S) ? VMAX_S  : vel_inc;
  assign y_n     = $signed({2'b00, y_q}) + vel_n;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      y_q     <= Y_START_V;
      vel_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      pend_q  <= pend_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    pend_d  = pend_q;

    unique case (state_q)
      ST_IDLE: begin
        // Bird is parked at spawn; the edge that starts the game is not
        // carried over as an impulse.
        y_d    = Y_START_V;
        vel_d  = '0;
        pend_d = 1'b0;
        if (start || flap_edge_q) begin
          state_d = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (tick_w) begin
          pend_d = 1'b0;
          if (y_n >= FLOOR_S) begin
            y_d     = Y_FLOOR_V;
            vel_d   = '0;
            state_d = ST_DEAD;
          end else if (y_n < TOP_S) begin
            y_d   = Y_TOP_V;
            vel_d = '0;
`ifdef BIRD_CEIL_KILL_EN
            state_d = ST_DEAD;
`else
            state_d = ST_PLAY;
`endif
          end else begin
            y_d   = y_n[Y_W-1:0];
            vel_d = vel_n[V_W-1:0];
          end
        end else begin
          // Any number of edges within a frame collapse into one impulse.
          pend_d = flap_now;
        end
      end

      ST_DEAD: begin
        // Position and velocity freeze; flap presses are discarded.
        pend_d = 1'b0;
        if (start) begin
          state_d = ST_IDLE;
          y_d     = Y_START_V;
          vel_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        y_d     = Y_START_V;
        vel_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state = state_q;
    dead  = (state_q == ST_DEAD);
    y     = y_q;
    vel   = vel_q;
  end

endmodule
